// File: rtl/spi_tx_pkg.sv
// Shared types and sizing helpers for the spi_tx serialiser.
package spi_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSMIT = 2'd1,
    HOLD     = 2'd2,
    GAP      = 2'd3
  } spi_tx_state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/spi_tx_if.sv
// Parallel request side plus 3-wire serial side of spi_tx.
interface spi_tx_if #(
  parameter int unsigned DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  trigger_in;
  logic                  ready_out;
  logic                  data_out;
  logic                  data_clk_out;
  logic                  sel_out;

  modport master (
    output data_in, trigger_in,
    input  ready_out, data_out, data_clk_out, sel_out
  );

  modport slave (
    input  data_in, trigger_in,
    output ready_out, data_out, data_clk_out, sel_out
  );
endinterface

// File: rtl/spi_tx_clk_div.sv
// Half-period tick generator: tick fires every HALF cycles, restarts from zero on clear.
module spi_tx_clk_div
  import spi_tx_pkg::*;
#(
  parameter int unsigned HALF = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr_i,
  output logic tick_o_c
);
  localparam int unsigned   CW   = cnt_w(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] hc_q, hc_d;

  always_comb begin
    hc_d = hc_q;
    if (clr_i || (hc_q == LAST)) begin
      hc_d = '0;
    end else begin
      hc_d = hc_q + CW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hc_q <= '0;
    end else begin
      hc_q <= hc_d;
    end
  end

  assign tick_o_c = !clr_i && (hc_q == LAST);

endmodule

// File: rtl/spi_tx.sv
// Serialises one DATA_WIDTH-bit word per request, MSB first, onto data/clock/select.
// Define SPI_TX_INPUT_REG_EN for a 1-entry input buffer that chains words across the gap.
module spi_tx
  import spi_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 10,
  parameter int unsigned DATA_CLK_PERIOD = 4
) (
  input logic     clk_in,
  input logic     rst_in,
  spi_tx_if.slave bus
);
  localparam int unsigned    HALF    = DATA_CLK_PERIOD / 2;
  localparam int unsigned    BCW     = cnt_w(DATA_WIDTH);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_WIDTH - 1);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_TRANSMIT = TRANSMIT;
  localparam logic [1:0] ST_HOLD     = HOLD;
  localparam logic [1:0] ST_GAP      = GAP;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bc_q, bc_d;
  logic                  dclk_q, dclk_d;
  logic                  sel_q, sel_d;
  logic                  dat_q, dat_d;
  logic                  rdy_q, rdy_d;
  logic                  accept, start, tick, div_clr;
  logic [DATA_WIDTH-1:0] start_word;
`ifdef SPI_TX_INPUT_REG_EN
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  bufv_q, bufv_d;
  logic                  from_buf;
`endif

  // Counter idles cleared so every word starts with a full low half-period.
  assign div_clr = (state_q == ST_IDLE);

  spi_tx_clk_div #(.HALF(HALF)) u_clk_div (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clr_i    (div_clr),
    .tick_o_c (tick)
  );

  assign accept = bus.trigger_in && rdy_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bc_d       = bc_q;
    dclk_d     = dclk_q;
    sel_d      = sel_q;
    dat_d      = dat_q;
    rdy_d      = rdy_q;
    start      = 1'b0;
    start_word = '0;
`ifdef SPI_TX_INPUT_REG_EN
    buf_d      = buf_q;
    bufv_d     = bufv_q;
    from_buf   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          start      = 1'b1;
          start_word = bus.data_in;
        end
      end
      ST_TRANSMIT: begin
        if (tick) begin
          if (!dclk_q) begin
            dclk_d = 1'b1;
          end else begin
            // Falling edge: advance to the next bit, or park after the last one.
            dclk_d = 1'b0;
            if (bc_q == BC_LAST) begin
              state_d = ST_HOLD;
            end else begin
              shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
              dat_d   = shift_q[DATA_WIDTH-2];
              bc_d    = bc_q + BCW'(1);
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          sel_d   = 1'b1;
          dat_d   = 1'b0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
`ifdef SPI_TX_INPUT_REG_EN
          if (bufv_q) begin
            start      = 1'b1;
            from_buf   = 1'b1;
            start_word = buf_q;
          end else if (accept) begin
            start      = 1'b1;
            start_word = bus.data_in;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d = ST_TRANSMIT;
      shift_d = start_word;
      dat_d   = start_word[DATA_WIDTH-1];
      sel_d   = 1'b0;
      dclk_d  = 1'b0;
      bc_d    = '0;
    end

`ifdef SPI_TX_INPUT_REG_EN
    // Drain first so a same-cycle accept overwrites the entry just consumed.
    if (from_buf) begin
      bufv_d = 1'b0;
    end
    if (accept && !(start && !from_buf)) begin
      buf_d  = bus.data_in;
      bufv_d = 1'b1;
    end
    rdy_d = !bufv_d;
`else
    rdy_d = (state_d == ST_IDLE);
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bc_q    <= '0;
      dclk_q  <= 1'b0;
      sel_q   <= 1'b1;
      dat_q   <= 1'b0;
      rdy_q   <= 1'b1;
`ifdef SPI_TX_INPUT_REG_EN
      buf_q   <= '0;
      bufv_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bc_q    <= bc_d;
      dclk_q  <= dclk_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      rdy_q   <= rdy_d;
`ifdef SPI_TX_INPUT_REG_EN
      buf_q   <= buf_d;
      bufv_q  <= bufv_d;
`endif
    end
  end

  assign bus.ready_out    = rdy_q;
  assign bus.data_out     = dat_q;
  assign bus.data_clk_out = dclk_q;
  assign bus.sel_out      = sel_q;

endmodule

// File: tb/tb_spi_tx.sv
// Scoreboard bench for spi_tx: two instances (clock periods 4 and 2), each watched by a
// reference SPI receiver that rebuilds words from rising-edge samples.
module tb_spi_tx;
  localparam int unsigned W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] din  [2];
  logic         trig [2];
  logic         rdy  [2];
  logic         dout [2];
  logic         dclk [2];
  logic         sel  [2];
  logic [W-1:0] exp_q [2][$];
  int vectors = 0;
  int miscompares = 0;

  spi_tx_if #(.DATA_WIDTH(W)) bus0 ();
  spi_tx_if #(.DATA_WIDTH(W)) bus1 ();

  assign bus0.data_in    = din[0];
  assign bus0.trigger_in = trig[0];
  assign bus1.data_in    = din[1];
  assign bus1.trigger_in = trig[1];
  assign rdy[0]  = bus0.ready_out;
  assign dout[0] = bus0.data_out;
  assign dclk[0] = bus0.data_clk_out;
  assign sel[0]  = bus0.sel_out;
  assign rdy[1]  = bus1.ready_out;
  assign dout[1] = bus1.data_out;
  assign dclk[1] = bus1.data_clk_out;
  assign sel[1]  = bus1.sel_out;

  spi_tx #(.DATA_WIDTH(W), .DATA_CLK_PERIOD(4)) u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus0.slave)
  );

  spi_tx #(.DATA_WIDTH(W), .DATA_CLK_PERIOD(2)) u_dut_p2 (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus1.slave)
  );

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_eq(input string name, input int act, input int exp);
    chk(act == exp, name, act, exp);
  endtask

  // Inputs change and DUT outputs are read 1 time unit after the falling clock edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Present a word once ready is seen; the word is expected by the receiver from then on.
  task automatic send(input int i, input logic [W-1:0] w, input bit hold);
    int n;
    n = 0;
    while (!rdy[i] && n < 500) begin
      step();
      n++;
    end
    chk(n < 500, $sformatf("dut%0d.ready_wait_timeout", i), n, 500);
    din[i]  = w;
    trig[i] = 1'b1;
    exp_q[i].push_back(w);
    step();
    chk_eq($sformatf("dut%0d.ready_after_accept", i), int'(rdy[i]), 0);
    if (!hold) trig[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (!(exp_q[i].size() == 0 && rdy[i] && sel[i]) && n < 2000) begin
      step();
      n++;
    end
    chk(n < 2000, $sformatf("dut%0d.idle_timeout", i), n, 2000);
  endtask

  // Reference receiver: shifts data in on each rising data clock, frames words by select.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int PER     = (g == 0) ? 4 : 2;
    localparam int SEL_LOW = int'(W) * PER + PER / 2;
    int nbits;

    initial begin
      logic         pc, ps, pd, inw, seen;
      logic [W-1:0] sh, e;
      int           lo, hi;
      pc = 1'b0; ps = 1'b1; pd = 1'b0; inw = 1'b0; seen = 1'b0;
      sh = '0; e = '0; lo = 0; hi = 2; nbits = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          pc = dclk[g]; ps = 1'b1; pd = dout[g];
          inw = 1'b0; nbits = 0; lo = 0; hi = 2;
          continue;
        end
        if (dclk[g] != pc)
          chk(!sel[g], $sformatf("dut%0d.clk_edge_while_deselected", g), int'(sel[g]), 0);
        if (dclk[g] && !pc) begin
          chk_eq($sformatf("dut%0d.data_stable_at_rise", g), int'(dout[g]), int'(pd));
          sh = {sh[W-2:0], dout[g]};
          nbits++;
        end
        if (!sel[g] && ps) begin
          if (seen) chk(hi >= 2, $sformatf("dut%0d.gap_cycles", g), hi, 2);
          inw = 1'b1; lo = 0; nbits = 0; sh = '0;
        end
        if (sel[g] && !ps && inw) begin
          chk_eq($sformatf("dut%0d.rising_edges", g), nbits, int'(W));
          chk_eq($sformatf("dut%0d.sel_low_cycles", g), lo, SEL_LOW);
          chk(exp_q[g].size() != 0, $sformatf("dut%0d.word_expected", g), 0, 1);
          if (exp_q[g].size() != 0) begin
            e = exp_q[g].pop_front();
            chk_eq($sformatf("dut%0d.word", g), int'(sh), int'(e));
          end
          inw = 1'b0; hi = 0; seen = 1'b1;
        end
        if (sel[g]) hi++;
        else        lo++;
        pc = dclk[g]; ps = sel[g]; pd = dout[g];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] junk;
    int           n;
    bit           hold;
    din[0] = '0; din[1] = '0; trig[0] = 1'b0; trig[1] = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk_eq($sformatf("dut%0d.reset_ready", i), int'(rdy[i]), 1);
      chk_eq($sformatf("dut%0d.reset_data", i), int'(dout[i]), 0);
      chk_eq($sformatf("dut%0d.reset_clk", i), int'(dclk[i]), 0);
      chk_eq($sformatf("dut%0d.reset_sel", i), int'(sel[i]), 1);
    end
    rst = 1'b0;
    step();

    // Single word and its ready turnaround.
    send(0, 10'h2A5, 1'b0);
    n = 1;
    while (!rdy[0] && n < 200) begin
      step();
      n++;
    end
    chk_eq("dut0.ready_latency", n, 45);
    wait_idle(0);

    // Back-to-back words with trigger held high.
    send(0, 10'h3FF, 1'b1);
    send(0, 10'h000, 1'b0);
    wait_idle(0);

    // Trigger while busy must be ignored.
    send(0, 10'h0C3, 1'b0);
    repeat (8) step();
    chk_eq("dut0.busy_not_ready", int'(rdy[0]), 0);
    din[0] = 10'h155; trig[0] = 1'b1;
    step();
    trig[0] = 1'b0;
    wait_idle(0);

    // Reset at the 5th rising edge aborts the word; a following word goes out cleanly.
    send(0, 10'h3C7, 1'b0);
    n = 0;
    while (g_mon[0].nbits != 5 && n < 200) begin
      step();
      n++;
    end
    chk_eq("dut0.reached_5th_edge", g_mon[0].nbits, 5);
    rst = 1'b1;
    junk = exp_q[0].pop_front();
    step();
    chk_eq("dut0.abort_sel", int'(sel[0]), 1);
    chk_eq("dut0.abort_clk", int'(dclk[0]), 0);
    chk_eq("dut0.abort_ready", int'(rdy[0]), 1);
    rst = 1'b0;
    step();
    send(0, 10'h0F0, 1'b0);
    wait_idle(0);

    // One-cycle clock phases.
    send(1, 10'h001, 1'b0);
    wait_idle(1);

    // Random words, random idle gaps, random back-to-back chaining.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 12; k++) begin
        hold = (k != 11) && ($urandom_range(0, 2) == 0);
        send(d, W'($urandom_range(0, 1023)), hold);
        if (!hold) repeat ($urandom_range(0, 6)) step();
      end
      wait_idle(d);
    end

    repeat (20) step();
    chk_eq("dut0.words_outstanding", exp_q[0].size(), 0);
    chk_eq("dut1.words_outstanding", exp_q[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
